// File: rtl/uart_baud_ctrl.sv
// Purpose: sequences a baud-rate change (drain UART traffic, pulse baud generator reset, settle, acknowledge).
// Latency: cfg_done 1 cycle after accept if rate unchanged, else 2+RST_CYCLES+SETTLE_CYCLES cycles after drain ends.
// Backpressure: cfg_ready low for the whole transaction; requests outside IDLE are ignored, never queued.
module uart_baud_ctrl #(
  parameter logic [19:0] DRAIN_TIMEOUT = 20'd1048575,
  parameter int          RST_CYCLES    = 4,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [1:0]  RESET_RATE    = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_rate,
  output logic       cfg_ready,
  output logic       cfg_done,
  output logic       cfg_err,
  input  logic       tx_busy,
  input  logic       rx_busy,
  output logic       tx_hold,
  output logic [1:0] bd_rate,
  output logic       gen_rst
);

  // One phase counter serves both the reset pulse and the settle window.
  localparam int PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  // Last cycle of the gen_rst pulse, then one release cycle still inside GRST
  // so the generator sees reset drop before the settle window starts.
  localparam logic [PH_W-1:0] RST_LAST    = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] RST_REL     = PH_W'(RST_CYCLES);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [19:0]     DRAIN_LAST  = DRAIN_TIMEOUT - 20'd1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    GRST   = 3'd2,
    SETTLE = 3'd3,
    ACK    = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t          state;
  logic [1:0]      rate_q;
  logic [19:0]     drain_cnt;
  logic [PH_W-1:0] phase_cnt;

  // Control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rate_q    <= RESET_RATE;
      drain_cnt <= '0;
      phase_cnt <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      tx_hold   <= 1'b0;
      bd_rate   <= RESET_RATE;
      gen_rst   <= 1'b0;
    end else begin
      // Completion pulses last exactly one cycle unless re-asserted below.
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            cfg_ready <= 1'b0;
            rate_q    <= cfg_rate;
            if (cfg_rate == bd_rate) begin
              // Nothing to change: acknowledge without disturbing traffic.
              state    <= ACK;
              cfg_done <= 1'b1;
            end else begin
              state     <= DRAIN;
              tx_hold   <= 1'b1;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          // Both directions idle wins over an expiring timeout on the same edge.
          if (!tx_busy && !rx_busy) begin
            state     <= GRST;
            bd_rate   <= rate_q;
            gen_rst   <= 1'b1;
            phase_cnt <= '0;
          end else if (drain_cnt == DRAIN_LAST) begin
            state   <= ERR;
            cfg_err <= 1'b1;
            tx_hold <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 20'd1;
          end
        end
        GRST: begin
          if (phase_cnt == RST_REL) begin
            state     <= SETTLE;
            phase_cnt <= '0;
          end else begin
            if (phase_cnt == RST_LAST) begin
              gen_rst <= 1'b0;
            end
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (phase_cnt == SETTLE_LAST) begin
            state    <= ACK;
            cfg_done <= 1'b1;
            tx_hold  <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ACK, ERR: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
          tx_hold   <= 1'b0;
          gen_rst   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Purpose: scoreboard bench for uart_baud_ctrl (default instance plus a DRAIN_TIMEOUT=8 instance).
// Latency: expectations carry pulse latency and gen_rst offset/width, measured from the accepting edge.
// Backpressure: requests wait for cfg_ready; each accepted request must retire with exactly one pulse.
module tb_uart_baud_ctrl;

  typedef struct {
    bit         err;
    int         lat;
    logic [1:0] rate;
    int         goff;
    int         glen;
    bit         hold;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       cfg_valid, cfg_ready, cfg_done, cfg_err;
  logic [1:0] cfg_rate, bd_rate;
  logic       tx_busy, rx_busy, tx_hold, gen_rst;

  logic       to_valid, to_ready, to_done, to_err;
  logic [1:0] to_rate, to_bd_rate;
  logic       to_rx_busy, to_tx_hold, to_gen_rst;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t q_main[$];
  exp_t q_to[$];

  // Monitor-owned tracking state.
  int n_acc = 0, n_acc_to = 0;
  int acc_main = 0, acc_to = 0;
  bit in_txn = 0, hold_seen = 0, ready_seen = 0, gen_rst_q = 0;
  int grst_start = -1, grst_len = 0;

  logic [1:0] hr;
  int         base;

  uart_baud_ctrl u_dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_rate(cfg_rate), .cfg_ready(cfg_ready),
    .cfg_done(cfg_done), .cfg_err(cfg_err),
    .tx_busy(tx_busy), .rx_busy(rx_busy),
    .tx_hold(tx_hold), .bd_rate(bd_rate), .gen_rst(gen_rst)
  );

  uart_baud_ctrl #(.DRAIN_TIMEOUT(20'd8)) u_to (
    .clk(clk), .rst(rst),
    .cfg_valid(to_valid), .cfg_rate(to_rate), .cfg_ready(to_ready),
    .cfg_done(to_done), .cfg_err(to_err),
    .tx_busy(1'b0), .rx_busy(to_rx_busy),
    .tx_hold(to_tx_hold), .bd_rate(to_bd_rate), .gen_rst(to_gen_rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(bit err, int lat, logic [1:0] rate, int goff, int glen, bit hold);
    exp_t e;
    e.err = err; e.lat = lat; e.rate = rate; e.goff = goff; e.glen = glen; e.hold = hold;
    return e;
  endfunction

  // Scoreboard: track each transaction from its accepting edge, retire it on the pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      q_main.delete();
      q_to.delete();
      in_txn    = 0;
      gen_rst_q = 0;
    end else begin
      if (in_txn) begin
        if (tx_hold)   hold_seen  = 1;
        if (cfg_ready) ready_seen = 1;
        if (gen_rst && !gen_rst_q) begin
          grst_start = cyc - acc_main;
          if (q_main.size() > 0) chk("bd_at_grst", int'(bd_rate), int'(q_main[0].rate));
        end
        if (gen_rst) grst_len++;
      end
      gen_rst_q = gen_rst;
      if (cfg_done || cfg_err) begin
        chk("done_err_excl", int'(cfg_done & cfg_err), 0);
        if (q_main.size() == 0) chk("unexpected_pulse", 1, 0);
        else begin
          e = q_main.pop_front();
          chk("kind", int'(cfg_err), int'(e.err));
          chk("latency", cyc - acc_main, e.lat);
          chk("bd_rate", int'(bd_rate), int'(e.rate));
          chk("tx_hold_end", int'(tx_hold), 0);
          chk("gen_rst_now", int'(gen_rst), 0);
          chk("hold_seen", int'(hold_seen), int'(e.hold));
          chk("grst_start", grst_start, e.goff);
          chk("grst_len", grst_len, e.glen);
          chk("ready_in_txn", int'(ready_seen), 0);
        end
        in_txn = 0;
      end
      if (cfg_valid && cfg_ready) begin
        n_acc++;
        acc_main   = cyc + 1;
        in_txn     = 1;
        hold_seen  = 0;
        ready_seen = 0;
        grst_start = -1;
        grst_len   = 0;
      end
      if (to_done || to_err) begin
        chk("to_excl", int'(to_done & to_err), 0);
        if (q_to.size() == 0) chk("to_unexpected_pulse", 1, 0);
        else begin
          e = q_to.pop_front();
          chk("to_kind", int'(to_err), int'(e.err));
          chk("to_latency", cyc - acc_to, e.lat);
          chk("to_bd_rate", int'(to_bd_rate), int'(e.rate));
          chk("to_tx_hold_end", int'(to_tx_hold), 0);
        end
      end
      if (to_valid && to_ready) begin
        n_acc_to++;
        acc_to = cyc + 1;
      end
    end
  end

  // Inputs change only 1 time unit after a rising edge.
  task automatic send(input logic [1:0] rate, input exp_t e, input bit keep);
    int n, b;
    b = n_acc;
    q_main.push_back(e);
    cfg_rate  = rate;
    cfg_valid = 1'b1;
    n = 0;
    while (n_acc == b && n < 100) begin @(posedge clk); #1; n++; end
    if (n_acc == b) chk("accept_timeout", 0, 1);
    if (!keep) cfg_valid = 1'b0;
  endtask

  task automatic send_to(input logic [1:0] rate, input exp_t e);
    int n, b;
    b = n_acc_to;
    q_to.push_back(e);
    to_rate  = rate;
    to_valid = 1'b1;
    n = 0;
    while (n_acc_to == b && n < 100) begin @(posedge clk); #1; n++; end
    if (n_acc_to == b) chk("to_accept_timeout", 0, 1);
    to_valid = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int bound);
    int n;
    n = 0;
    while (((which ? q_to.size() : q_main.size()) != 0) && n < bound) begin
      @(posedge clk); #1; n++;
    end
    if ((which ? q_to.size() : q_main.size()) != 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_rate = 2'b00; tx_busy = 1'b0; rx_busy = 1'b0;
    to_valid = 1'b0; to_rate = 2'b00; to_rx_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bd_rate", int'(bd_rate), 0);
    chk("rst_gen_rst", int'(gen_rst), 0);
    chk("rst_tx_hold", int'(tx_hold), 0);
    chk("rst_done", int'(cfg_done), 0);
    chk("rst_err", int'(cfg_err), 0);
    chk("rst_ready", int'(cfg_ready), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); chk("ready_before_edge", int'(cfg_ready), 0);
    @(negedge clk); chk("ready_first_edge", int'(cfg_ready), 1);
    @(posedge clk); #1;

    // Same rate as reset value: immediate acknowledge, no hold, no generator reset.
    send(2'b00, mk(0, 0, 2'b00, -1, 0, 0), 0);
    wait_done(0, 50);
    // Immediate-idle change to 9600.
    send(2'b11, mk(0, 22, 2'b11, 1, 4, 1), 0);
    wait_done(0, 100);
    // Transmitter busy for 100 cycles after the accept.
    tx_busy = 1'b1;
    send(2'b01, mk(0, 122, 2'b01, 101, 4, 1), 0);
    repeat (100) @(posedge clk);
    #1 tx_busy = 1'b0;
    wait_done(0, 100);
    // Receiver busy for 5 cycles.
    rx_busy = 1'b1;
    send(2'b10, mk(0, 27, 2'b10, 6, 4, 1), 0);
    repeat (5) @(posedge clk);
    #1 rx_busy = 1'b0;
    wait_done(0, 100);
    send(2'b10, mk(0, 0, 2'b10, -1, 0, 0), 0);
    wait_done(0, 50);

    // Timeout instance: receiver stuck busy aborts after 8 drain cycles.
    to_rx_busy = 1'b1;
    send_to(2'b10, mk(1, 8, 2'b00, -1, 0, 1));
    chk("to_hold_in_drain", int'(to_tx_hold), 1);
    wait_done(1, 50);
    // Idle seen on the very edge the timeout expires: idle wins.
    send_to(2'b10, mk(0, 29, 2'b10, -1, 0, 1));
    repeat (7) @(posedge clk);
    #1 to_rx_busy = 1'b0;
    wait_done(1, 100);

    // Reset in the middle of SETTLE aborts without a pulse.
    send(2'b11, mk(0, 22, 2'b11, 1, 4, 1), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_bd_rate", int'(bd_rate), 3);
    chk("pre_rst_gen_rst", int'(gen_rst), 0);
    rst = 1'b0;
    #1;
    chk("abort_bd_rate", int'(bd_rate), 0);
    chk("abort_gen_rst", int'(gen_rst), 0);
    chk("abort_tx_hold", int'(tx_hold), 0);
    chk("abort_done", int'(cfg_done), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send(2'b11, mk(0, 22, 2'b11, 1, 4, 1), 0);
    wait_done(0, 100);

    // cfg_valid held high with alternating rates: one accept per IDLE visit.
    base = n_acc;
    for (int i = 0; i < 4; i++) begin
      hr = (i % 2 == 0) ? 2'b01 : 2'b10;
      send(hr, mk(0, 22, hr, 1, 4, 1), 1);
      wait_done(0, 100);
    end
    cfg_valid = 1'b0;
    chk("hold_accepts", n_acc - base, 4);

    repeat (30) @(posedge clk);
    chk("queues_empty", q_main.size() + q_to.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
